// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: condition codes, NZCV bit positions and default widths.
package cpu_defs_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 4;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/alu_flag_writeback_cond_eval.sv
// Combinational condition-code evaluator; shared with branch resolution.
module cond_eval
  import cpu_defs_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[N_BIT];
  assign z = nzcv[Z_BIT];
  assign c = nzcv[C_BIT];
  assign v = nzcv[V_BIT];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_writeback.sv
// Post-ALU stage: condition check, NZCV update and a one-entry valid/ready
// register feeding register-file writeback.
module alu_flag_writeback
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_nzcv,
  input  logic [3:0]        in_cond,
  input  logic              in_s,
  input  logic              in_cmp,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  input  logic              flags_wr_en,
  input  logic [3:0]        flags_wr_data,
  output logic [3:0]        flags_nzcv,
  output logic              carry_to_alu,
  output logic              cond_pass,
  output logic [CNT_W-1:0]  squash_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic              out_wr_en_q, out_wr_en_d;
  logic [3:0]        flags_q, flags_d;
  logic [CNT_W-1:0]  squash_cnt_q, squash_cnt_d;
  logic              accept;

  // Condition is judged against the registered flags only; no in_nzcv bypass.
  cond_eval u_cond_eval (
    .cond (in_cond),
    .nzcv (flags_q),
    .pass (cond_pass)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_wr_en_d  = out_wr_en_q;
    flags_d      = flags_q;
    squash_cnt_d = squash_cnt_q;

    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = in_result;
      out_rd_d     = in_rd;
      out_wr_en_d  = cond_pass && in_wr_en && !in_cmp;
      if (cond_pass && (in_s || in_cmp)) begin
        flags_d = in_nzcv;
      end
      if (!cond_pass && (squash_cnt_q != {CNT_W{1'b1}})) begin
        squash_cnt_d = squash_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Direct flag writes override any same-cycle instruction flag update.
    if (flags_wr_en) begin
      flags_d = flags_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_wr_en_q  <= 1'b0;
      flags_q      <= 4'b0000;
      squash_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_wr_en_q  <= out_wr_en_d;
      flags_q      <= flags_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_rd       = out_rd_q;
  assign out_wr_en    = out_wr_en_q;
  assign flags_nzcv   = flags_q;
  assign carry_to_alu = flags_q[C_BIT];
  assign squash_cnt   = squash_cnt_q;

endmodule

// File: tb/tb_alu_flag_writeback.sv
// Directed checks of alu_flag_writeback plus a random-stall stream scoreboard.
module tb_alu_flag_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_valid2;
  logic        in_ready, in_ready2;
  logic [31:0] in_result;
  logic [3:0]  in_nzcv, in_cond;
  logic        in_s, in_cmp, in_wr_en;
  logic [3:0]  in_rd;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_result, out_result2;
  logic [3:0]  out_rd, out_rd2;
  logic        out_wr_en, out_wr_en2;
  logic        flags_wr_en;
  logic [3:0]  flags_wr_data;
  logic [3:0]  flags_nzcv, flags_nzcv2;
  logic        carry_to_alu, carry_to_alu2;
  logic        cond_pass, cond_pass2;
  logic [15:0] squash_cnt;
  logic [1:0]  squash_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_flag_writeback #(.DATA_W(32), .RD_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_nzcv(in_nzcv), .in_cond(in_cond),
    .in_s(in_s), .in_cmp(in_cmp), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .flags_wr_en(flags_wr_en), .flags_wr_data(flags_wr_data),
    .flags_nzcv(flags_nzcv), .carry_to_alu(carry_to_alu),
    .cond_pass(cond_pass), .squash_cnt(squash_cnt)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  alu_flag_writeback #(.DATA_W(32), .RD_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_result(in_result), .in_nzcv(in_nzcv), .in_cond(in_cond),
    .in_s(in_s), .in_cmp(in_cmp), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_result(out_result2), .out_rd(out_rd2), .out_wr_en(out_wr_en2),
    .flags_wr_en(flags_wr_en), .flags_wr_data(flags_wr_data),
    .flags_nzcv(flags_nzcv2), .carry_to_alu(carry_to_alu2),
    .cond_pass(cond_pass2), .squash_cnt(squash_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Conditions come in complementary pairs; odd codes invert the even base.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n ~^ v);
      3'd6: base = ~z & (n ~^ v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] nzcv,
                       input logic [3:0] cond, input logic s, input logic cmp,
                       input logic [3:0] rd, input logic wr);
    in_valid  = v;
    in_result = res;
    in_nzcv   = nzcv;
    in_cond   = cond;
    in_s      = s;
    in_cmp    = cmp;
    in_rd     = rd;
    in_wr_en  = wr;
  endtask

  logic [31:0] exp_res_q[$];
  logic [3:0]  exp_rd_q[$];
  logic        mdl_valid;
  int          sent, recvd, cycles;
  logic [31:0] cur_res;

  initial begin
    reset = 1'b1;
    in_valid2 = 1'b0;
    out_ready = 1'b1;
    flags_wr_en = 1'b0;
    flags_wr_data = 4'b0000;
    drive(1'b0, 32'h0, 4'h0, 4'hE, 1'b0, 1'b0, 4'h0, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();

    check("rst_flags", flags_nzcv, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_squash", squash_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_carry", carry_to_alu, 1'b0);
    check("rst_out_result", out_result, 32'h0);

    drive(1'b1, 32'h0, 4'b0100, 4'b1110, 1'b1, 1'b0, 4'd3, 1'b1);
    #1 check("al_cond_pass", cond_pass, 1'b1);
    step();
    check("al_out_valid", out_valid, 1'b1);
    check("al_out_rd", out_rd, 4'd3);
    check("al_out_wr_en", out_wr_en, 1'b1);
    check("al_flags", flags_nzcv, 4'b0100);
    check("al_out_result", out_result, 32'h0);

    drive(1'b1, 32'h11, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd4, 1'b1);
    #1 check("eq_cond_pass", cond_pass, 1'b1);
    step();
    check("eq_out_wr_en", out_wr_en, 1'b1);
    check("eq_out_rd", out_rd, 4'd4);
    check("eq_out_result", out_result, 32'h11);

    drive(1'b1, 32'h22, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd5, 1'b1);
    #1 check("ne_cond_pass", cond_pass, 1'b0);
    step();
    check("ne_out_wr_en", out_wr_en, 1'b0);
    check("ne_squash", squash_cnt, 16'd1);
    check("ne_flags_kept", flags_nzcv, 4'b0100);
    check("ne_out_result", out_result, 32'h22);

    drive(1'b1, 32'h33, 4'b0010, 4'b1110, 1'b0, 1'b1, 4'd6, 1'b1);
    step();
    check("cmp_out_wr_en", out_wr_en, 1'b0);
    check("cmp_flags", flags_nzcv, 4'b0010);
    check("cmp_carry", carry_to_alu, 1'b1);

    drive(1'b1, 32'hABCD, 4'b0110, 4'b1110, 1'b1, 1'b0, 4'd7, 1'b1);
    flags_wr_en = 1'b1;
    flags_wr_data = 4'b1001;
    step();
    flags_wr_en = 1'b0;
    check("prio_flags", flags_nzcv, 4'b1001);
    check("prio_out_result", out_result, 32'hABCD);
    check("prio_out_rd", out_rd, 4'd7);
    check("prio_out_wr_en", out_wr_en, 1'b1);

    // Flags 1001 -> 0000; the next EQ must see the new Z=0.
    drive(1'b1, 32'h1, 4'b0000, 4'b1110, 1'b1, 1'b0, 4'd1, 1'b1);
    step();
    drive(1'b0, 32'h2, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'd2, 1'b1);
    #1 check("dep_cond_pass", cond_pass, 1'b0);
    step();
    check("drain_out_valid", out_valid, 1'b0);
    check("dep_squash_idle", squash_cnt, 16'd1);

    drive(1'b1, 32'h55, 4'b0000, 4'b1110, 1'b0, 1'b0, 4'd5, 1'b1);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'h66, 4'b0000, 4'b1110, 1'b0, 1'b0, 4'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_in_ready", in_ready, 1'b0);
      step();
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_result", out_result, 32'h55);
      check("stall_out_rd", out_rd, 4'd5);
    end
    out_ready = 1'b1;
    #1 check("release_in_ready", in_ready, 1'b1);
    step();
    check("release_out_result", out_result, 32'h66);
    check("release_out_rd", out_rd, 4'd6);
    in_valid = 1'b0;
    step();

    for (int f = 0; f < 16; f++) begin
      flags_wr_en = 1'b1;
      flags_wr_data = 4'(f);
      step();
      flags_wr_en = 1'b0;
      for (int c = 0; c < 16; c++) begin
        in_cond = 4'(c);
        #1 check($sformatf("cond_%0d_nzcv_%0d", c, f), cond_pass, ref_cond(4'(c), 4'(f)));
      end
    end

    // Random-stall stream against a one-entry reference register.
    in_cond = 4'b1110; in_s = 1'b0; in_cmp = 1'b0; in_wr_en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    mdl_valid = 1'b0;
    sent = 0; recvd = 0; cycles = 0;
    cur_res = $urandom;
    while ((recvd < 100) && (cycles < 3000)) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 100) && ($urandom_range(0, 2) != 0);
      in_result = cur_res;
      in_rd     = 4'(sent);
      #1;
      check("strm_in_ready", in_ready, !mdl_valid || out_ready);
      check("strm_out_valid", out_valid, mdl_valid);
      if (mdl_valid && out_ready) begin
        if (exp_res_q.size() == 0) begin
          check("strm_unexpected_entry", 1'b1, 1'b0);
        end else begin
          check("strm_out_result", out_result, exp_res_q.pop_front());
          check("strm_out_rd", out_rd, exp_rd_q.pop_front());
          recvd++;
        end
      end
      if (in_valid && (!mdl_valid || out_ready)) begin
        exp_res_q.push_back(cur_res);
        exp_rd_q.push_back(4'(sent));
        sent++;
        cur_res = $urandom;
        mdl_valid = 1'b1;
      end else if (out_ready) begin
        mdl_valid = 1'b0;
      end
      step();
      cycles++;
    end
    check("strm_received", recvd, 100);
    check("strm_sent", sent, 100);
    in_valid = 1'b0;
    step();

    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD, 4'b1111, 4'b1110, 1'b1, 1'b0, 4'd9, 1'b1);
    step();
    in_valid = 1'b0;
    check("pre_rst_out_valid", out_valid, 1'b1);
    check("pre_rst_flags", flags_nzcv, 4'b1111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_flags", flags_nzcv, 4'b0000);
    check("mid_rst_out_result", out_result, 32'h0);
    check("mid_rst_out_wr_en", out_wr_en, 1'b0);
    check("mid_rst_squash", squash_cnt, 16'd0);
    out_ready = 1'b1;

    drive(1'b0, 32'h7, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'd1, 1'b1);
    in_valid2 = 1'b1;
    step();
    step();
    check("sat_pre", squash_cnt2, 2'd2);
    step();
    check("sat_full", squash_cnt2, 2'd3);
    step();
    check("sat_hold", squash_cnt2, 2'd3);
    check("sat_wr_en", out_wr_en2, 1'b0);
    in_valid2 = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_flag_writeback.md
Name: alu_flag_writeback

Overview:
- Stage directly downstream of the ALU.
- Each cycle it accepts one ALU result with its N/Z/C/V flags and the instruction's condition field.
- It evaluates the condition against the architectural NZCV register, conditionally updates NZCV, and registers the result toward register-file writeback using a valid/ready handshake.
- It also drives the stored C flag back to the ALU carry input, for ADC/SBC/RSC and logical carry pass-through.

Parameters:
- DATA_W, 32, ALU result width
- RD_W, 4, destination register index width
- CNT_W, 16, squash counter width

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  ALU stage holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_result  in  DATA_W  ALU result
- in_nzcv  in  4  ALU flags {N,Z,C,V}
- in_cond  in  4  condition code
- in_s  in  1  S-bit: update flags
- in_cmp  in  1  TST/TEQ/CMP/CMN class: flags always updated, no register write
- in_rd  in  RD_W  destination register
- in_wr_en  in  1  instruction writes in_rd
- out_valid  out  1  writeback entry valid
- out_ready  in  1  register file accepts entry
- out_result  out  DATA_W  registered result
- out_rd  out  RD_W  registered destination
- out_wr_en  out  1  perform register write (0 when squashed)
- flags_wr_en  in  1  direct NZCV write (MSR-flags)
- flags_wr_data  in  4  value for the direct write
- flags_nzcv  out  4  architectural NZCV register
- carry_to_alu  out  1  equals flags_nzcv[1]
- cond_pass  out  1  combinational condition result for the current in_cond against the current flags_nzcv
- squash_cnt  out  CNT_W  count of accepted instructions whose condition failed

Behaviour:
- Reset (synchronous, clk edge with reset=1) values:
  - flags_nzcv=4'b0000, carry_to_alu=0.
  - out_valid=0, out_result=0, out_rd=0, out_wr_en=0, squash_cnt=0.
  - Reset mid-operation discards any held entry.
- Handshake:
  - in_ready = !out_valid || out_ready. Full throughput, one-entry register, no combinational path from in_valid to in_ready.
  - accept = in_valid && in_ready.
  - On accept: out_valid<=1 and out_result/out_rd load from the inputs.
  - Else if out_valid && out_ready: out_valid<=0; the data fields hold their last values.
  - Held entry: when out_valid && !out_ready, out_* stay stable.
- Condition evaluation uses flags_nzcv before this instruction's update:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 NV 0.
- On accept with cond_pass=1:
  - out_wr_en<=in_wr_en && !in_cmp.
  - If in_s || in_cmp: flags_nzcv<=in_nzcv.
- On accept with cond_pass=0:
  - out_wr_en<=0, flags unchanged.
  - squash_cnt increments and saturates at all-ones; it does not wrap.
- Flag write priority:
  - flags_wr_en=1 loads flags_wr_data the same cycle.
  - If the same cycle also has an accepted flag-updating instruction, flags_wr_data wins and the instruction's flag update is dropped. Its result is still registered.
- Back-to-back dependence: the instruction accepted in cycle t+1 evaluates its condition against flags written at edge t. No bypass of in_nzcv into cond_pass.
- Latency: one cycle from accept to out_valid. Flags are visible one cycle after accept.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - condition-code constants COND_EQ..COND_NV.
  - NZCV bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - DATA_W and RD_W defaults.
- One sub-module: cond_eval, a combinational map from (cond[3:0], nzcv[3:0]) to pass. It is reused later by branch logic.

Test Plan:
- Reset then idle -> flags_nzcv=0000, out_valid=0, squash_cnt=0, in_ready=1.
- Accept in_result=0x0000_0000, in_nzcv=0100, in_cond=AL, in_s=1, in_wr_en=1, in_rd=3 -> next cycle out_valid=1, out_rd=3, out_wr_en=1, flags_nzcv=0100. Then cond=EQ passes and cond=NE is squashed (out_wr_en=0, squash_cnt=1).
- CMP with in_nzcv=0010, in_wr_en=1, in_cmp=1, cond=AL -> out_wr_en=0, flags_nzcv=0010, carry_to_alu=1.
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and out_* stable. Release -> next queued input accepted in the same cycle, no loss or duplication over a 100-transaction random-stall stream checked against a reference model.
- flags_wr_en=1 with flags_wr_data=1001 in the same cycle as an accepted in_s=1 with in_nzcv=0110 -> flags_nzcv=1001, result still registered.
- Exercise all 16 conditions across all 16 NZCV values (256 cases) against the table. Force squash_cnt to all-ones minus 1 and squash twice -> saturates at 0xFFFF. Assert reset while out_valid=1 -> out_valid=0 and flags=0 next edge.
